// File: rtl/hex_keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
//   deb_state_e : debounce FSM states
//   scan_res_e  : outcome of one full four-column scan
//   KEYMAP      : hex code for each (row, column) key position, indexed [row][col]
package hex_keypad_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      KEY   = 2'd1,
      MULTI = 2'd2
   } scan_res_e;

   // Bottom row: '*' reads as E, '#' reads as F.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM for the keypad scanner, stepped once per completed scan.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_scan_done  : one-cycle strobe, a full scan result is on i_result/i_code
//   i_result     : NONE / KEY / MULTI (MULTI is handled like NONE)
//   i_code       : hex code of the single pressed key when i_result == KEY
//   o_key_valid  : one-cycle pulse when a press is accepted
//   o_key_code   : code of the last accepted key
//   o_key_held   : high from acceptance until the release is debounced
module keypad_debounce
   import hex_keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_scan_done,
   input  scan_res_e  i_result,
   input  logic [3:0] i_code,
   output logic       o_key_valid,
   output logic [3:0] o_key_code,
   output logic       o_key_held
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   deb_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_cand;
   logic             r_key_valid;
   logic [3:0]       r_key_code;
   logic             r_key_held;

   logic w_is_key;
   logic w_is_cand;
   logic w_is_held_key;

   assign w_is_key      = (i_result == KEY);
   assign w_is_cand     = w_is_key && (i_code == r_cand);
   assign w_is_held_key = w_is_key && (i_code == r_key_code);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_cand      <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_key_held  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (i_scan_done) begin
            case (r_state)
               IDLE: begin
                  if (w_is_key) begin
                     r_cand  <= i_code;
                     r_cnt   <= CNT_W'(1);
                     r_state <= PRESS_WAIT;
                  end
               end
               PRESS_WAIT: begin
                  if (w_is_cand) begin
                     // This scan is the DEBOUNCE_SCANS-th consecutive match.
                     if (r_cnt == CNT_LAST) begin
                        r_state     <= PRESSED;
                        r_key_valid <= 1'b1;
                        r_key_code  <= r_cand;
                        r_key_held  <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end else if (w_is_key) begin
                     r_cand <= i_code;
                     r_cnt  <= CNT_W'(1);
                  end else begin
                     r_state <= IDLE;
                  end
               end
               PRESSED: begin
                  if (!w_is_held_key) begin
                     r_cnt   <= CNT_W'(1);
                     r_state <= RELEASE_WAIT;
                  end
               end
               RELEASE_WAIT: begin
                  if (w_is_held_key) begin
                     r_state <= PRESSED;
                  end else if (r_cnt == CNT_LAST) begin
                     r_state    <= IDLE;
                     r_key_held <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_key_valid = r_key_valid;
   assign o_key_code  = r_key_code;
   assign o_key_held  = r_key_held;

endmodule

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner with debounce and a 16-bit digit entry register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   row       : keypad rows, active-low, asynchronous to clk
//   col       : keypad columns, active-low, one low at a time
//   clr       : synchronous clear of value (wins over a same-cycle key)
//   key_code  : code of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high while the accepted key is considered pressed
//   value     : entry register, newest digit in [3:0]
module hex_keypad_scan
   import hex_keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] value
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col_idx;
   // Running scan result for the columns sampled so far (count saturates at 2).
   logic [1:0]       r_acc_cnt;
   logic [1:0]       r_acc_row;
   logic [1:0]       r_acc_col;
   logic [15:0]      r_value;

   logic             w_sample;
   logic             w_scan_done;
   logic [3:0]       w_pressed;
   logic [2:0]       w_col_cnt;
   logic [1:0]       w_col_row;
   logic [1:0]       w_base_cnt;
   logic [2:0]       w_sum;
   logic [1:0]       w_sat_cnt;
   logic [1:0]       w_pos_row;
   logic [1:0]       w_pos_col;
   scan_res_e        w_result;
   logic [3:0]       w_code;
   logic             w_key_valid;
   logic [3:0]       w_key_code;
   logic             w_key_held;

   // Rows are asynchronous to clk; idle (released) value is all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= row;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_sample    = (r_div == DIV_LAST);
   assign w_scan_done = w_sample && (r_col_idx == 2'd3);
   assign col         = ~(4'b0001 << r_col_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= '0;
         r_col_idx <= '0;
      end else if (w_sample) begin
         r_div     <= '0;
         r_col_idx <= r_col_idx + 2'd1;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   assign w_pressed = ~r_row_sync;

   always_comb begin
      w_col_cnt = '0;
      w_col_row = '0;
      for (int i = 0; i < 4; i++) begin
         if (w_pressed[i]) begin
            w_col_cnt = w_col_cnt + 3'd1;
            w_col_row = 2'(i);
         end
      end
   end

   // Column 0 starts a fresh scan, so ignore whatever the previous scan left behind.
   assign w_base_cnt = (r_col_idx == 2'd0) ? 2'd0 : r_acc_cnt;
   assign w_sum      = {1'b0, w_base_cnt} + w_col_cnt;
   assign w_sat_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_pos_row  = (w_col_cnt != 3'd0) ? w_col_row : r_acc_row;
   assign w_pos_col  = (w_col_cnt != 3'd0) ? r_col_idx : r_acc_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_cnt <= '0;
         r_acc_row <= '0;
         r_acc_col <= '0;
      end else if (w_sample) begin
         r_acc_cnt <= w_sat_cnt;
         r_acc_row <= w_pos_row;
         r_acc_col <= w_pos_col;
      end
   end

   // The column-3 sample completes the scan in the same cycle, so the FSM sees it directly.
   always_comb begin
      unique case (w_sat_cnt)
         2'd0:    w_result = NONE;
         2'd1:    w_result = KEY;
         default: w_result = MULTI;
      endcase
   end

   assign w_code = KEYMAP[w_pos_row][w_pos_col];

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .i_scan_done (w_scan_done),
      .i_result    (w_result),
      .i_code      (w_code),
      .o_key_valid (w_key_valid),
      .o_key_code  (w_key_code),
      .o_key_held  (w_key_held)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
      end else if (clr) begin
         r_value <= '0;
      end else if (w_key_valid) begin
         r_value <= {r_value[11:0], w_key_code};
      end
   end

   assign key_valid = w_key_valid;
   assign key_code  = w_key_code;
   assign key_held  = w_key_held;
   assign value     = r_value;

endmodule

// File: tb/tb_hex_keypad_scan.sv
module tb_hex_keypad_scan;

   localparam int unsigned SD = 4;
   localparam int unsigned DS = 3;
   localparam int LAT_MAX = 2 + (DS + 1) * 4 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] value;

   logic        key_mat [4][4];
   int          tests = 0;
   int          fails = 0;
   int          pulses = 0;
   logic [3:0]  exp_q [$];
   logic [3:0]  got_q [$];
   logic [15:0] exp_val = 16'h0000;

   hex_keypad_scan #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .clr       (clr),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .value     (value)
   );

   always #5 clk = ~clk;

   // Keypad model: a closed switch pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_mat[r][c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         got_q.push_back(key_code);
         pulses++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            key_mat[r][c] = 1'b0;
   endtask

   task automatic tap(input int r, input int c, input logic [3:0] code);
      exp_q.push_back(code);
      exp_val = {exp_val[11:0], code};
      key_mat[r][c] = 1'b1;
      cycles(72);
      key_mat[r][c] = 1'b0;
      cycles(80);
   endtask

   task automatic test_reset();
      logic [3:0] one;
      logic [3:0] exp_col;
      one = 4'b0001;
      release_all();
      #1 rst = 1'b1;
      cycles(3);
      tests++;
      if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 ||
          value !== 16'h0 || key_code !== 4'h0)
         begin
            fails++;
            $display("FAIL reset_state: col=%b valid=%b held=%b value=%h code=%h, want 1110 0 0 0000 0",
                     col, key_valid, key_held, value, key_code);
         end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 16; k++) begin
         exp_col = ~(one << ((k / SD) % 4));
         tests++;
         if (col !== exp_col) begin
            fails++;
            $display("FAIL col_sequence[%0d]: col=%b want %b", k, col, exp_col);
         end
         cycles(1);
      end
      cycles(48);
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL idle_no_valid: pulses=%0d want 0", pulses);
      end
   endtask

   task automatic test_single_press();
      int p0;
      int n;
      logic [3:0] g;
      logic [3:0] e;
      p0 = pulses;
      exp_q.push_back(4'h6);
      exp_val = {exp_val[11:0], 4'h6};
      key_mat[1][2] = 1'b1;
      n = 0;
      while (pulses == p0 && n < 80) begin
         cycles(1);
         n++;
      end
      tests++;
      if (pulses == p0 || n > LAT_MAX) begin
         fails++;
         $display("FAIL press_latency: cycles=%0d pulses=%0d want <= %0d", n, pulses - p0, LAT_MAX);
      end
      cycles(80 - n);
      tests++;
      if (pulses - p0 != 1) begin
         fails++;
         $display("FAIL single_pulse_count: got %0d want 1", pulses - p0);
      end
      tests++;
      if (got_q.size() == 0) begin
         fails++;
         $display("FAIL single_code: no pulse observed, want 6");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            fails++;
            $display("FAIL single_code: got %h want %h", g, e);
         end
      end
      tests++;
      if (value !== exp_val || key_held !== 1'b1) begin
         fails++;
         $display("FAIL single_value_held: value=%h held=%b want %h 1", value, key_held, exp_val);
      end
      key_mat[1][2] = 1'b0;
      n = 0;
      while (key_held === 1'b1 && n < 100) begin
         cycles(1);
         n++;
      end
      tests++;
      if (key_held !== 1'b0 || n < 32 || n > 72) begin
         fails++;
         $display("FAIL release_timing: held=%b after %0d cycles, want 0 within 32..72", key_held, n);
      end
      cycles(10);
      tests++;
      if (pulses - p0 != 1) begin
         fails++;
         $display("FAIL release_no_pulse: got %0d pulses want 1", pulses - p0);
      end
   endtask

   task automatic test_bounce();
      int p0;
      logic [3:0] g;
      logic [3:0] e;
      p0 = pulses;
      for (int i = 0; i < 8; i++) begin
         key_mat[2][2] = (i % 2 == 0);
         cycles(5);
      end
      tests++;
      if (pulses != p0) begin
         fails++;
         $display("FAIL bounce_quiet: got %0d pulses want 0", pulses - p0);
      end
      exp_q.push_back(4'h9);
      exp_val = {exp_val[11:0], 4'h9};
      key_mat[2][2] = 1'b1;
      cycles(80);
      tests++;
      if (pulses - p0 != 1) begin
         fails++;
         $display("FAIL bounce_pulse_count: got %0d want 1", pulses - p0);
      end
      tests++;
      if (got_q.size() == 0) begin
         fails++;
         $display("FAIL bounce_code: no pulse observed, want 9");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            fails++;
            $display("FAIL bounce_code: got %h want %h", g, e);
         end
      end
      key_mat[2][2] = 1'b0;
      cycles(80);
      tests++;
      if (value !== exp_val) begin
         fails++;
         $display("FAIL bounce_value: got %h want %h", value, exp_val);
      end
   endtask

   task automatic test_entry_shift();
      int kr [5] = '{0, 0, 0, 0, 1};
      int kc [5] = '{0, 1, 2, 3, 3};
      logic [3:0]  kcode [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};
      logic [15:0] kval [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23AB};
      logic [3:0] g;
      logic [3:0] e;
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      exp_val = 16'h0000;
      tests++;
      if (value !== 16'h0000) begin
         fails++;
         $display("FAIL clr_value: got %h want 0000", value);
      end
      for (int i = 0; i < 5; i++) begin
         tap(kr[i], kc[i], kcode[i]);
         tests++;
         if (got_q.size() != 1) begin
            fails++;
            $display("FAIL entry_pulse[%0d]: got %0d pulses want 1", i, got_q.size());
            got_q.delete();
            exp_q.delete();
         end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== e || value !== kval[i] || value !== exp_val) begin
               fails++;
               $display("FAIL entry[%0d]: code=%h value=%h want %h %h", i, g, value, e, kval[i]);
            end
         end
      end
   endtask

   task automatic test_multi_key();
      int p0;
      logic [3:0] g;
      logic [3:0] e;
      p0 = pulses;
      key_mat[0][0] = 1'b1;
      key_mat[1][1] = 1'b1;
      cycles(80);
      tests++;
      if (pulses != p0) begin
         fails++;
         $display("FAIL multi_rejected: got %0d pulses want 0", pulses - p0);
      end
      exp_q.push_back(4'h1);
      exp_val = {exp_val[11:0], 4'h1};
      key_mat[1][1] = 1'b0;
      cycles(80);
      tests++;
      if (pulses - p0 != 1 || got_q.size() == 0) begin
         fails++;
         $display("FAIL multi_then_single: got %0d pulses want 1", pulses - p0);
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            fails++;
            $display("FAIL multi_then_single: code %h want %h", g, e);
         end
      end
      release_all();
      cycles(80);
   endtask

   task automatic test_clear_collision();
      int p0;
      int n;
      logic hit;
      logic [3:0] g;
      logic [3:0] e;
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      exp_val = 16'h0000;
      got_q.delete();
      exp_q.delete();
      tap(0, 0, 4'h1);
      tap(0, 1, 4'h2);
      tap(0, 2, 4'h3);
      tap(1, 0, 4'h4);
      got_q.delete();
      exp_q.delete();
      tests++;
      if (value !== 16'h1234 || value !== exp_val) begin
         fails++;
         $display("FAIL preload_1234: got %h want 1234", value);
      end
      p0 = pulses;
      exp_q.push_back(4'hF);
      key_mat[3][2] = 1'b1;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 100) begin
         @(negedge clk);
         if (key_valid === 1'b1) hit = 1'b1;
         else n++;
      end
      #1;
      clr = 1'b1;
      @(negedge clk);
      #1;
      clr = 1'b0;
      exp_val = 16'h0000;
      tests++;
      if (!hit || value !== 16'h0000 || key_code !== 4'hF || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL clr_collision: seen=%b value=%h code=%h valid=%b want 1 0000 F 0",
                  hit, value, key_code, key_valid);
      end
      cycles(20);
      key_mat[3][2] = 1'b0;
      cycles(80);
      tests++;
      if (pulses - p0 != 1 || got_q.size() == 0) begin
         fails++;
         $display("FAIL clr_collision_pulse: got %0d pulses want 1", pulses - p0);
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e || value !== exp_val) begin
            fails++;
            $display("FAIL clr_collision_code: code=%h value=%h want %h %h", g, value, e, exp_val);
         end
      end
   endtask

   task automatic test_async_reset();
      int p0;
      logic [3:0] g;
      logic [3:0] e;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(4'h2);
      key_mat[0][1] = 1'b1;
      cycles(72);
      tests++;
      if (key_held !== 1'b1 || got_q.size() != 1) begin
         fails++;
         $display("FAIL pre_reset_accept: held=%b pulses=%0d want 1 1", key_held, got_q.size());
      end
      got_q.delete();
      exp_q.delete();
      #2 rst = 1'b1;
      #1;
      tests++;
      if (col !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 ||
          value !== 16'h0 || key_code !== 4'h0)
         begin
            fails++;
            $display("FAIL async_reset: col=%b held=%b valid=%b value=%h code=%h, want 1110 0 0 0000 0",
                     col, key_held, key_valid, value, key_code);
         end
      @(negedge clk);
      rst = 1'b0;
      #1;
      p0 = pulses;
      exp_q.push_back(4'h2);
      exp_val = 16'h0002;
      cycles(80);
      tests++;
      if (pulses - p0 != 1 || got_q.size() == 0) begin
         fails++;
         $display("FAIL reaccept_after_reset: got %0d pulses want 1", pulses - p0);
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e || value !== exp_val) begin
            fails++;
            $display("FAIL reaccept_code: code=%h value=%h want %h %h", g, value, e, exp_val);
         end
      end
      release_all();
      cycles(80);
   endtask

   initial begin
      release_all();
      test_reset();
      test_single_press();
      test_bounce();
      test_entry_shift();
      test_multi_key();
      test_clear_collision();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
